// File: rtl/ex_branch.sv
// Branch execution stage: resolves branch/jump conditions, hands the next PC to fetch
// over a valid/ready redirect, and broadcasts the JAL/JALR link value.
module ex_branch #(
   parameter int dataWidth  = 32,
   parameter int addrWidth  = 32,
   parameter int tagWidth   = 4,
   parameter int newopWidth = 6,
   parameter int TAG_FREE   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  ex_branch_en,
   input  logic [dataWidth-1:0]  exsrc1_in,
   input  logic [dataWidth-1:0]  exsrc2_in,
   input  logic [addrWidth-1:0]  expc_in,
   input  logic [newopWidth-1:0] exaluop_in,
   input  logic [addrWidth-1:0]  exoffset_in,
   input  logic [tagWidth-1:0]   exdst_tag_in,
   output logic                  in_ready,
   output logic                  redirect_valid,
   output logic [addrWidth-1:0]  redirect_pc,
   output logic                  redirect_taken,
   input  logic                  redirect_ready,
   output logic                  wb_en,
   output logic [tagWidth-1:0]   wb_tag,
   output logic [dataWidth-1:0]  wb_data,
   output logic                  err_overrun
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [newopWidth-1:0] OP_JAL  = newopWidth'(1);
   localparam logic [newopWidth-1:0] OP_JALR = newopWidth'(2);
   localparam logic [newopWidth-1:0] OP_BEQ  = newopWidth'(3);
   localparam logic [newopWidth-1:0] OP_BNE  = newopWidth'(4);
   localparam logic [newopWidth-1:0] OP_BLT  = newopWidth'(5);
   localparam logic [newopWidth-1:0] OP_BGE  = newopWidth'(6);
   localparam logic [newopWidth-1:0] OP_BLTU = newopWidth'(7);
   localparam logic [newopWidth-1:0] OP_BGEU = newopWidth'(8);
   localparam logic [tagWidth-1:0]   TAG_FREE_V = tagWidth'(TAG_FREE);

   state_t               state_r, state_s;
   logic [addrWidth-1:0] redirect_pc_r, redirect_pc_s;
   logic                 redirect_taken_r, redirect_taken_s;
   logic                 wb_en_r, wb_en_s;
   logic [tagWidth-1:0]  wb_tag_r, wb_tag_s;
   logic [dataWidth-1:0] wb_data_r, wb_data_s;
   logic                 err_overrun_r, err_overrun_s;

   logic                 accept_s;
   logic                 is_jump_s;
   logic                 is_branch_s;
   logic                 cond_s;
   logic [addrWidth-1:0] seq_s;
   logic [addrWidth-1:0] br_target_s;
   logic [addrWidth-1:0] jalr_target_s;

   assign seq_s         = expc_in + addrWidth'(4);
   assign br_target_s   = expc_in + exoffset_in;
   assign jalr_target_s = (addrWidth'(exsrc1_in) + exoffset_in) & ~addrWidth'(1);

   // Decode the op class and evaluate the branch condition.
   always_comb begin
      is_jump_s   = 1'b0;
      is_branch_s = 1'b0;
      cond_s      = 1'b0;
      case (exaluop_in)
         OP_JAL, OP_JALR: is_jump_s = 1'b1;
         OP_BEQ: begin
            is_branch_s = 1'b1;
            cond_s      = (exsrc1_in == exsrc2_in);
         end
         OP_BNE: begin
            is_branch_s = 1'b1;
            cond_s      = (exsrc1_in != exsrc2_in);
         end
         OP_BLT: begin
            is_branch_s = 1'b1;
            cond_s      = ($signed(exsrc1_in) < $signed(exsrc2_in));
         end
         OP_BGE: begin
            is_branch_s = 1'b1;
            cond_s      = ($signed(exsrc1_in) >= $signed(exsrc2_in));
         end
         OP_BLTU: begin
            is_branch_s = 1'b1;
            cond_s      = (exsrc1_in < exsrc2_in);
         end
         OP_BGEU: begin
            is_branch_s = 1'b1;
            cond_s      = (exsrc1_in >= exsrc2_in);
         end
         default: begin
            is_jump_s   = 1'b0;
            is_branch_s = 1'b0;
            cond_s      = 1'b0;
         end
      endcase
   end

   assign accept_s = ex_branch_en && (state_r == IDLE) && rdy;

   // Next-state and next-output computation; everything holds while rdy is low.
   always_comb begin
      state_s          = state_r;
      redirect_pc_s    = redirect_pc_r;
      redirect_taken_s = redirect_taken_r;
      wb_en_s          = wb_en_r;
      wb_tag_s         = wb_tag_r;
      wb_data_s        = wb_data_r;
      err_overrun_s    = err_overrun_r;
      if (rdy) begin
         wb_en_s   = 1'b0;
         wb_tag_s  = TAG_FREE_V;
         wb_data_s = {dataWidth{1'b0}};
         // An issue while busy is dropped; the pending redirect is untouched.
         if (ex_branch_en && (state_r == HOLD)) begin
            err_overrun_s = 1'b1;
         end else begin
            err_overrun_s = err_overrun_r;
         end
         case (state_r)
            IDLE: begin
               if (accept_s && (is_jump_s || is_branch_s)) begin
                  state_s = HOLD;
                  if (is_jump_s) begin
                     redirect_taken_s = 1'b1;
                     redirect_pc_s    = (exaluop_in == OP_JALR) ? jalr_target_s : br_target_s;
                     if (exdst_tag_in != TAG_FREE_V) begin
                        wb_en_s   = 1'b1;
                        wb_tag_s  = exdst_tag_in;
                        wb_data_s = dataWidth'(seq_s);
                     end else begin
                        wb_en_s = 1'b0;
                     end
                  end else begin
                     redirect_taken_s = cond_s;
                     redirect_pc_s    = cond_s ? br_target_s : seq_s;
                  end
               end else begin
                  state_s = IDLE;
               end
            end
            HOLD: begin
               if (redirect_ready) begin
                  state_s = IDLE;
               end else begin
                  state_s = HOLD;
               end
            end
            default: state_s = IDLE;
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= IDLE;
         redirect_pc_r    <= {addrWidth{1'b0}};
         redirect_taken_r <= 1'b0;
         wb_en_r          <= 1'b0;
         wb_tag_r         <= TAG_FREE_V;
         wb_data_r        <= {dataWidth{1'b0}};
         err_overrun_r    <= 1'b0;
      end else begin
         state_r          <= state_s;
         redirect_pc_r    <= redirect_pc_s;
         redirect_taken_r <= redirect_taken_s;
         wb_en_r          <= wb_en_s;
         wb_tag_r         <= wb_tag_s;
         wb_data_r        <= wb_data_s;
         err_overrun_r    <= err_overrun_s;
      end
   end

   assign in_ready       = (state_r == IDLE);
   assign redirect_valid = (state_r == HOLD);
   assign redirect_pc    = redirect_pc_r;
   assign redirect_taken = redirect_taken_r;
   assign wb_en          = wb_en_r;
   assign wb_tag         = wb_tag_r;
   assign wb_data        = wb_data_r;
   assign err_overrun    = err_overrun_r;

endmodule

// File: tb/tb_ex_branch.sv
// Self-checking bench for ex_branch: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level reference model.
module tb_ex_branch;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        ex_branch_en;
   logic [31:0] exsrc1_in;
   logic [31:0] exsrc2_in;
   logic [31:0] expc_in;
   logic [5:0]  exaluop_in;
   logic [31:0] exoffset_in;
   logic [3:0]  exdst_tag_in;
   logic        in_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_taken;
   logic        redirect_ready;
   logic        wb_en;
   logic [3:0]  wb_tag;
   logic [31:0] wb_data;
   logic        err_overrun;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit          m_pend;
   logic [31:0] m_pc;
   bit          m_taken;
   bit          m_wbe;
   logic [3:0]  m_wbt;
   logic [31:0] m_wbd;
   bit          m_err;

   ex_branch dut (
      .clk(clk), .rst(rst), .rdy(rdy), .ex_branch_en(ex_branch_en),
      .exsrc1_in(exsrc1_in), .exsrc2_in(exsrc2_in), .expc_in(expc_in),
      .exaluop_in(exaluop_in), .exoffset_in(exoffset_in), .exdst_tag_in(exdst_tag_in),
      .in_ready(in_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_taken(redirect_taken), .redirect_ready(redirect_ready),
      .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data), .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Architectural effect of one instruction: taken flag and next PC.
   function automatic void resolve(input int op, input logic [31:0] s1, input logic [31:0] s2,
                                   input logic [31:0] pc, input logic [31:0] off,
                                   output bit taken, output logic [31:0] npc);
      taken = 1'b0;
      case (op)
         1: taken = 1'b1;
         2: taken = 1'b1;
         3: taken = (s1 == s2);
         4: taken = (s1 != s2);
         5: taken = ($signed(s1) < $signed(s2));
         6: taken = !($signed(s1) < $signed(s2));
         7: taken = (s1 < s2);
         8: taken = !(s1 < s2);
         default: taken = 1'b0;
      endcase
      if (op == 2)      npc = (s1 + off) & 32'hFFFF_FFFE;
      else if (taken)   npc = pc + off;
      else              npc = pc + 32'd4;
   endfunction

   task automatic model_step();
      bit          tk;
      logic [31:0] np;
      bit          was_pend;
      int          op;
      if (rst) begin
         m_pend = 1'b0; m_pc = 32'd0; m_taken = 1'b0;
         m_wbe = 1'b0; m_wbt = 4'd0; m_wbd = 32'd0; m_err = 1'b0;
      end else if (rdy) begin
         was_pend = m_pend;
         op = int'(exaluop_in);
         m_wbe = 1'b0; m_wbt = 4'd0; m_wbd = 32'd0;
         if (ex_branch_en && was_pend) m_err = 1'b1;
         if (was_pend && redirect_ready) m_pend = 1'b0;
         if (ex_branch_en && !was_pend && op >= 1 && op <= 8) begin
            resolve(op, exsrc1_in, exsrc2_in, expc_in, exoffset_in, tk, np);
            m_pend = 1'b1; m_pc = np; m_taken = tk;
            if (op <= 2 && exdst_tag_in != 4'd0) begin
               m_wbe = 1'b1; m_wbt = exdst_tag_in; m_wbd = expc_in + 32'd4;
            end
         end
      end
   endtask

   task automatic check_all();
      check("in_ready",       {31'd0, in_ready},       {31'd0, !m_pend});
      check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_pend});
      check("redirect_pc",    redirect_pc,             m_pc);
      check("redirect_taken", {31'd0, redirect_taken}, {31'd0, m_taken});
      check("wb_en",          {31'd0, wb_en},          {31'd0, m_wbe});
      check("wb_tag",         {28'd0, wb_tag},         {28'd0, m_wbt});
      check("wb_data",        wb_data,                 m_wbd);
      check("err_overrun",    {31'd0, err_overrun},    {31'd0, m_err});
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] pc, input logic [31:0] off, input logic [3:0] tag);
      ex_branch_en = 1'b1; exaluop_in = op; exsrc1_in = s1; exsrc2_in = s2;
      expc_in = pc; exoffset_in = off; exdst_tag_in = tag;
      cycle();
      ex_branch_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; ex_branch_en = 1'b0; redirect_ready = 1'b1;
      exsrc1_in = 32'd0; exsrc2_in = 32'd0; expc_in = 32'd0; exaluop_in = 6'd0;
      exoffset_in = 32'd0; exdst_tag_in = 4'd0;
      cycle(); cycle();
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_valid", {31'd0, redirect_valid}, 32'd0);
      rst = 1'b0;
      cycle();

      // BEQ taken, one-cycle latency, back to idle
      issue(6'd3, 32'd5, 32'd5, 32'h100, 32'h20, 4'd0);
      check("t1_valid", {31'd0, redirect_valid}, 32'd1);
      check("t1_pc", redirect_pc, 32'h120);
      check("t1_taken", {31'd0, redirect_taken}, 32'd1);
      cycle();
      check("t1_idle", {31'd0, in_ready}, 32'd1);

      // Signed versus unsigned compare
      issue(6'd5, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 4'd0);
      check("t2_blt_taken", {31'd0, redirect_taken}, 32'd1);
      cycle();
      issue(6'd7, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 4'd0);
      check("t2_bltu_taken", {31'd0, redirect_taken}, 32'd0);
      check("t2_bltu_pc", redirect_pc, 32'h304);
      cycle();

      // JALR link write-back, JAL without destination
      issue(6'd2, 32'h1003, 32'd0, 32'h200, 32'd4, 4'd3);
      check("t3_pc", redirect_pc, 32'h1006);
      check("t3_wb_en", {31'd0, wb_en}, 32'd1);
      check("t3_wb_tag", {28'd0, wb_tag}, 32'd3);
      check("t3_wb_data", wb_data, 32'h204);
      cycle();
      check("t3_wb_pulse", {31'd0, wb_en}, 32'd0);
      issue(6'd1, 32'd0, 32'd0, 32'h200, 32'h10, 4'd0);
      check("t3_jal_nowb", {31'd0, wb_en}, 32'd0);
      cycle();

      // Back-pressure and overrun
      redirect_ready = 1'b0;
      issue(6'd1, 32'd0, 32'd0, 32'h400, 32'h40, 4'd0);
      cycle();
      issue(6'd3, 32'd1, 32'd1, 32'h800, 32'h8, 4'd0);
      cycle();
      check("t4_hold_pc", redirect_pc, 32'h440);
      check("t4_hold_rdy", {31'd0, in_ready}, 32'd0);
      check("t4_overrun", {31'd0, err_overrun}, 32'd1);
      redirect_ready = 1'b1;
      cycle();
      check("t4_release", {31'd0, in_ready}, 32'd1);

      // Wrap-around and rdy freeze
      redirect_ready = 1'b0;
      issue(6'd1, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 4'd5);
      check("t5_wrap_pc", redirect_pc, 32'h4);
      check("t5_wrap_link", wb_data, 32'h0);
      rdy = 1'b0; redirect_ready = 1'b1;
      cycle(); cycle();
      check("t5_freeze_valid", {31'd0, redirect_valid}, 32'd1);
      check("t5_freeze_wb", {31'd0, wb_en}, 32'd1);
      rdy = 1'b1;
      cycle();

      // Reset while holding
      redirect_ready = 1'b0;
      issue(6'd4, 32'd1, 32'd2, 32'h600, 32'h10, 4'd0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("t6_valid", {31'd0, redirect_valid}, 32'd0);
      check("t6_in_ready", {31'd0, in_ready}, 32'd1);
      check("t6_err", {31'd0, err_overrun}, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst            = ($urandom_range(0, 199) == 0);
         rdy            = ($urandom_range(0, 7) != 0);
         ex_branch_en   = $urandom_range(0, 1);
         redirect_ready = $urandom_range(0, 2) != 0;
         exaluop_in     = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(9, 63))
                                                       : 6'($urandom_range(0, 8));
         exsrc1_in      = $urandom;
         exsrc2_in      = $urandom_range(0, 1) ? exsrc1_in : $urandom;
         expc_in        = $urandom;
         exoffset_in    = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 255));
         exdst_tag_in   = 4'($urandom_range(0, 15));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_branch.md
Name: ex_branch

Overview:
- Branch execution stage directly downstream of the branch reservation station.
- Each cycle, consumes at most one issued branch/jump packet: operands, PC, op, offset and destination tag.
- Resolves the condition and computes the next PC, which it hands to instruction fetch over a valid/ready redirect handshake.
- For JAL/JALR, broadcasts the link value (PC+4) on its result bus to the reservation stations and ROB.

Parameters:
dataWidth, 32, operand/result width
addrWidth, 32, PC/offset width
tagWidth, 4, result tag width
newopWidth, 6, op code width
TAG_FREE, 0, tag value meaning "no destination"

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rdy  in  1  global enable; when low, all state holds and outputs are frozen
ex_branch_en  in  1  issue valid from reservation station
exsrc1_in  in  dataWidth  operand rs1
exsrc2_in  in  dataWidth  operand rs2
expc_in  in  addrWidth  instruction PC
exaluop_in  in  newopWidth  op code
exoffset_in  in  addrWidth  sign-extended immediate
exdst_tag_in  in  tagWidth  destination tag (JAL/JALR)
in_ready  out  1  unit can accept an issue this cycle
redirect_valid  out  1  next-PC packet valid to fetch
redirect_pc  out  addrWidth  resolved next PC
redirect_taken  out  1  1 = control transfer taken
redirect_ready  in  1  fetch accepts redirect
wb_en  out  1  link result broadcast valid
wb_tag  out  tagWidth  link result tag
wb_data  out  dataWidth  link value
err_overrun  out  1  sticky: issue arrived while in_ready=0

Behaviour:
- Op encoding: NOP=0, JAL=1, JALR=2, BEQ=3, BNE=4, BLT=5, BGE=6, BLTU=7, BGEU=8. Any other code behaves as NOP.
- Reset values:
  - All outputs 0; in_ready=1; wb_tag=TAG_FREE; FSM in IDLE.
  - Reset mid-HOLD discards the pending redirect.
- rdy=0: no state changes, no acceptance, outputs unchanged.
- States:
  - IDLE: in_ready=1, redirect_valid=0.
  - HOLD: in_ready=0, redirect_valid=1, redirect_pc/redirect_taken stable.
- Accept rule: an issue is accepted when ex_branch_en && in_ready && rdy.
  - On accept of a non-NOP op, the FSM moves to HOLD at the next edge. Latency is 1 cycle: redirect_valid is high in the cycle after issue.
  - On accept of a NOP, no effect and the FSM stays in IDLE.
- HOLD -> IDLE on the edge where redirect_valid && redirect_ready. A new issue is not accepted in that same cycle, since in_ready=0 in HOLD.
- Arithmetic (mod 2^addrWidth, wraps silently):
  - seq = pc+4.
  - Branch target = pc+offset.
  - JAL target = pc+offset.
  - JALR target = (src1+offset) & ~1.
- Compare:
  - BLT/BGE use signed comparison.
  - BLTU/BGEU use unsigned comparison.
  - BEQ/BNE use equality.
- Redirect packet:
  - Conditional branches: redirect_pc = taken ? target : seq; redirect_taken = cond.
  - JAL/JALR: redirect_taken=1, redirect_pc=target.
  - A redirect is issued even for a not-taken branch, because fetch stalls on every branch.
- Writeback:
  - For JAL/JALR with dst_tag != TAG_FREE: wb_en=1 for exactly one cycle (the cycle after accept), wb_tag=dst_tag, wb_data=pc+4.
  - wb_en does not wait on redirect_ready.
  - Otherwise wb_en=0, wb_tag=TAG_FREE, wb_data=0.
- Overrun: ex_branch_en=1 while in_ready=0 (rdy=1) drops the packet and sets err_overrun. err_overrun clears only on rst. The pending redirect is unaffected.
- Misaligned targets are not checked. The low bit is cleared only for JALR.

Test Plan:
1. BEQ, src1=src2=5, pc=0x100, off=0x20, redirect_ready=1 -> next cycle redirect_valid=1, pc=0x120, taken=1, wb_en=0; the following cycle returns to IDLE with in_ready=1.
2. BLT, src1=0xFFFFFFFF, src2=1 -> taken=1. BLTU with the same operands -> taken=0, redirect_pc=pc+4.
3. JALR, src1=0x1003, off=4, pc=0x200, tag=3 -> redirect_pc=0x1006, wb_en pulse with tag=3, data=0x204; JAL with tag=TAG_FREE -> wb_en=0.
4. JAL issued with redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc held stable, in_ready=0; a second issue in that window sets err_overrun and is dropped; ready=1 -> IDLE next edge.
5. JAL with pc=0xFFFFFFFC, off=8 -> target 0x4 and link 0x0 (wrap). rdy=0 during HOLD -> everything frozen even with redirect_ready=1.
6. rst asserted in HOLD -> next cycle redirect_valid=0, in_ready=1, err_overrun=0, wb_en=0.
